// File: rtl/i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : i2c_master_ctrl
// Purpose : Single-master I2C controller; one register write or one-byte read
//           per START request, open-drain SCL/SDA with quarter-period phasing.
// Rev     : 1.0
// ============================================================================
module i2c_master_ctrl #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       SYSTEM_CLK,
   input  logic       RESET,
   input  logic       START,
   input  logic       RW,
   input  logic [6:0] DEV_ADDR,
   input  logic [7:0] REG_ADDR,
   input  logic [7:0] WDATA,
   output logic [7:0] RDATA,
   output logic       BUSY,
   output logic       DONE,
   output logic       ACK_ERR,
   output logic       SCL,
   inout  wire        SDA
);

   typedef enum logic [3:0] {
      IDLE      = 4'd0,
      S_START   = 4'd1,
      ADDR      = 4'd2,
      ADDR_ACK  = 4'd3,
      REG       = 4'd4,
      REG_ACK   = 4'd5,
      WDAT      = 4'd6,
      WDAT_ACK  = 4'd7,
      RDAT      = 4'd8,
      RDAT_NACK = 4'd9,
      S_STOP    = 4'd10
   } state_t;

   localparam logic [7:0] C_DIV_LAST = 8'(CLK_DIV - 1);

   state_t     state_q, state_d;
   logic [1:0] quarter_q, quarter_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] div_q, div_d;
   logic [7:0] addr_q, addr_d;
   logic [7:0] reg_q, reg_d;
   logic [7:0] wdata_q, wdata_d;
   logic [6:0] rx_q, rx_d;
   logic [7:0] rdata_q, rdata_d;
   logic       ack_err_q, ack_err_d;
   logic       done_q, done_d;

   logic       w_tick;
   logic [1:0] w_last_quarter;
   logic [7:0] w_tx_byte;
   logic       w_tx_bit;
   logic       w_sda_in;
   logic       w_scl_low;
   logic       w_sda_low;

   assign w_sda_in = SDA;

   always_ff @(posedge SYSTEM_CLK) begin
      if (RESET) begin
         state_q   <= IDLE;
         quarter_q <= '0;
         bit_q     <= '0;
         div_q     <= '0;
         addr_q    <= '0;
         reg_q     <= '0;
         wdata_q   <= '0;
         rx_q      <= '0;
         rdata_q   <= '0;
         ack_err_q <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         quarter_q <= quarter_d;
         bit_q     <= bit_d;
         div_q     <= div_d;
         addr_q    <= addr_d;
         reg_q     <= reg_d;
         wdata_q   <= wdata_d;
         rx_q      <= rx_d;
         rdata_q   <= rdata_d;
         ack_err_q <= ack_err_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      quarter_d = quarter_q;
      bit_d     = bit_q;
      div_d     = div_q;
      addr_d    = addr_q;
      reg_d     = reg_q;
      wdata_d   = wdata_q;
      rx_d      = rx_q;
      rdata_d   = rdata_q;
      ack_err_d = ack_err_q;
      done_d    = 1'b0;
      w_scl_low = 1'b0;
      w_sda_low = 1'b0;
      w_tx_byte = '0;

      w_tick = (div_q == C_DIV_LAST);
      case (state_q)
         S_START: w_last_quarter = 2'd1;
         S_STOP:  w_last_quarter = 2'd2;
         default: w_last_quarter = 2'd3;
      endcase

      case (state_q)
         ADDR:    w_tx_byte = addr_q;
         REG:     w_tx_byte = reg_q;
         WDAT:    w_tx_byte = wdata_q;
         default: w_tx_byte = '0;
      endcase
      w_tx_bit = w_tx_byte[3'd7 - bit_q];

      if (state_q == IDLE) begin
         div_d     = '0;
         quarter_d = '0;
         bit_d     = '0;
         if (START) begin
            addr_d    = {DEV_ADDR, RW};
            reg_d     = REG_ADDR;
            wdata_d   = WDATA;
            ack_err_d = 1'b0;
            state_d   = S_START;
         end
      end else if (w_tick) begin
         div_d = '0;
         // Bus is sampled as SCL has been high for a full quarter (entry to Q3).
         if (quarter_q == 2'd2) begin
            case (state_q)
               ADDR_ACK, REG_ACK, WDAT_ACK: begin
                  if (w_sda_in) ack_err_d = 1'b1;
               end
               RDAT: begin
                  rx_d = {rx_q[5:0], w_sda_in};
                  if (bit_q == 3'd7) rdata_d = {rx_q, w_sda_in};
               end
               default: ;
            endcase
         end
         if (quarter_q != w_last_quarter) begin
            quarter_d = quarter_q + 2'd1;
         end else begin
            quarter_d = '0;
            case (state_q)
               S_START: state_d = ADDR;
               ADDR: begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = ADDR_ACK;
               end
               REG: begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = REG_ACK;
               end
               WDAT: begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = WDAT_ACK;
               end
               RDAT: begin
                  bit_d = bit_q + 3'd1;
                  if (bit_q == 3'd7) state_d = RDAT_NACK;
               end
               ADDR_ACK: state_d = ack_err_q ? S_STOP : (addr_q[0] ? RDAT : REG);
               REG_ACK:  state_d = ack_err_q ? S_STOP : WDAT;
               WDAT_ACK, RDAT_NACK: state_d = S_STOP;
               S_STOP: begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
               default: state_d = IDLE;
            endcase
         end
      end else begin
         div_d = div_q + 8'd1;
      end

      // Open-drain drive: SCL low for Q0/Q1 of each bit slot, high otherwise.
      case (state_q)
         S_START: w_sda_low = (quarter_q == 2'd1);
         ADDR, REG, WDAT: begin
            w_scl_low = (quarter_q < 2'd2);
            w_sda_low = ~w_tx_bit;
         end
         ADDR_ACK, REG_ACK, WDAT_ACK, RDAT, RDAT_NACK: begin
            w_scl_low = (quarter_q < 2'd2);
         end
         S_STOP: begin
            w_scl_low = (quarter_q == 2'd0);
            w_sda_low = (quarter_q != 2'd2);
         end
         default: ;
      endcase
   end

   assign SCL     = w_scl_low ? 1'b0 : 1'bz;
   assign SDA     = w_sda_low ? 1'b0 : 1'bz;
   assign RDATA   = rdata_q;
   assign BUSY    = (state_q != IDLE);
   assign DONE    = done_q;
   assign ACK_ERR = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_i2c_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_master_ctrl
// Purpose : Scoreboard bench for i2c_master_ctrl with a bus-level slave model.
// Rev     : 1.0
// ============================================================================
module tb_i2c_master_ctrl;

   localparam int         CLK_DIV  = 4;
   localparam logic [6:0] SLV_ADDR = 7'h23;

   typedef struct {
      logic [23:0] bytes;
      int          nb;
      logic [2:0]  acks;
      logic        ack_err;
      logic [7:0]  rdata;
      int          done_cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       rw;
   logic [6:0] dev;
   logic [7:0] ra;
   logic [7:0] wd;
   logic [7:0] rdata;
   logic       busy;
   logic       done;
   logic       ack_err;
   wire        scl_w;
   wire        sda_w;
   logic       slv_low = 1'b0;

   int         n_cmp = 0;
   int         n_bad = 0;
   int         cyc   = 0;
   exp_t       sb_q[$];
   logic [7:0] model_rdata;
   logic [7:0] slv_rd_byte;

   // bus monitor / slave state
   logic        p_scl = 1'b1;
   logic        p_sda = 1'b1;
   logic        p_done = 1'b0;
   logic        in_txn = 1'b0;
   int          slots = 0;
   int          falls = 0;
   int          last_fall = 0;
   int          n_start = 0;
   int          n_stop = 0;
   int          obs_nb = 0;
   logic [7:0]  shreg = '0;
   logic [23:0] obs_bytes = '0;
   logic [2:0]  obs_acks = '0;
   logic        addressed = 1'b0;
   logic        reading = 1'b0;

   pullup (scl_w);
   pullup (sda_w);
   assign sda_w = slv_low ? 1'b0 : 1'bz;

   i2c_master_ctrl #(.CLK_DIV(CLK_DIV)) dut (
      .SYSTEM_CLK (clk),
      .RESET      (rst),
      .START      (start),
      .RW         (rw),
      .DEV_ADDR   (dev),
      .REG_ADDR   (ra),
      .WDATA      (wd),
      .RDATA      (rdata),
      .BUSY       (busy),
      .DONE       (done),
      .ACK_ERR    (ack_err),
      .SCL        (scl_w),
      .SDA        (sda_w)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: what the bus and the host ports should show for one request.
   function automatic exp_t model(input logic r, input logic [6:0] d, input logic [7:0] a,
                                  input logic [7:0] w, input logic [7:0] s, input int acc);
      exp_t e;
      logic hit;
      hit       = (d == SLV_ADDR);
      e.bytes   = {16'h0, d, r};
      e.nb      = 1;
      e.acks    = {2'b00, ~hit};
      if (hit && !r) begin
         e.bytes = {d, r, a, w};
         e.nb    = 3;
         e.acks  = 3'b000;
      end
      if (hit && r) begin
         e.bytes = {8'h0, d, r, s};
         e.nb    = 2;
         e.acks  = 3'b001;
      end
      e.ack_err  = ~hit;
      e.rdata    = (hit && r) ? s : model_rdata;
      e.done_cyc = acc + (5 + 36 * e.nb) * CLK_DIV + 1;
      return e;
   endfunction

   task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] a,
                        input logic [7:0] w, input logic [7:0] s, input bit push, input bit lead);
      exp_t e;
      if (lead) @(negedge clk);
      slv_rd_byte = s;
      start = 1'b1;
      rw    = r;
      dev   = d;
      ra    = a;
      wd    = w;
      if (push) begin
         e = model(r, d, a, w, s, cyc);
         model_rdata = e.rdata;
         sb_q.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
      rw    = 1'($urandom);
      dev   = 7'($urandom);
      ra    = 8'($urandom);
      wd    = 8'($urandom);
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (sb_q.size() != 0 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (sb_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL done_timeout: %0d responses outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic wait_done();
      int k;
      k = 0;
      while (done !== 1'b1 && k < 1000) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", done, 1'b1);
   endtask

   // Bus monitor, slave model and scoreboard consumer, all at the falling clock edge.
   always @(negedge clk) begin
      logic s, d;
      int   b, pos;
      exp_t e;
      s = scl_w;
      d = sda_w;
      if (rst) begin
         in_txn  = 1'b0;
         slots   = 0;
         falls   = 0;
         slv_low = 1'b0;
         n_start = 0;
         n_stop  = 0;
      end else begin
         if (p_scl && s && (p_sda != d)) begin
            if (!d) begin
               chk("start_not_nested", in_txn, 1'b0);
               in_txn    = 1'b1;
               slots     = 0;
               falls     = 0;
               obs_nb    = 0;
               obs_bytes = '0;
               obs_acks  = '0;
               shreg     = '0;
               addressed = 1'b0;
               reading   = 1'b0;
               slv_low   = 1'b0;
               n_start++;
            end else begin
               chk("stop_inside_txn", in_txn, 1'b1);
               in_txn = 1'b0;
               n_stop++;
            end
         end
         if (in_txn && !p_scl && s) begin
            pos = slots % 9;
            if (pos < 8) begin
               shreg = {shreg[6:0], d};
            end else begin
               obs_bytes = {obs_bytes[15:0], shreg};
               obs_acks  = {obs_acks[1:0], d};
               obs_nb++;
               if (slots == 8) begin
                  addressed = (shreg[7:1] == SLV_ADDR);
                  reading   = shreg[0];
               end
            end
            slots++;
         end
         if (in_txn && p_scl && !s) begin
            if (falls > 0) chk("scl_period", cyc - last_fall, 4 * CLK_DIV);
            last_fall = cyc;
            falls++;
            b   = slots / 9;
            pos = slots % 9;
            if (pos == 8)
               slv_low = (b == 0) ? (shreg[7:1] == SLV_ADDR) : (addressed && !reading);
            else
               slv_low = addressed && reading && (b == 1) && !slv_rd_byte[7 - pos];
         end
         if (done) begin
            chk("done_one_cycle", p_done, 1'b0);
            if (sb_q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got DONE, expected none (cycle %0d)", cyc);
            end else begin
               e = sb_q.pop_front();
               chk("done_cycle", cyc, e.done_cyc);
               chk("bus_byte_count", obs_nb, e.nb);
               chk("bus_bytes", obs_bytes, e.bytes);
               chk("bus_acks", obs_acks, e.acks);
               chk("ack_err", ack_err, e.ack_err);
               chk("rdata", rdata, e.rdata);
               chk("busy_at_done", busy, 1'b0);
               chk("start_count", n_start, 1);
               chk("stop_count", n_stop, 1);
            end
            n_start = 0;
            n_stop  = 0;
         end
      end
      p_done = done;
      p_scl  = s;
      p_sda  = d;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit b2b;
      int k;
      rst = 1'b1; start = 1'b0; rw = 1'b0; dev = '0; ra = '0; wd = '0;
      slv_rd_byte = '0; model_rdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_rdata", rdata, 8'h00);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_ack_err", ack_err, 1'b0);
      chk("reset_scl", scl_w, 1'b1);
      chk("reset_sda", sda_w, 1'b1);
      rst = 1'b0;

      issue(1'b0, 7'h23, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b1);
      wait_idle();
      issue(1'b1, 7'h23, 8'h00, 8'h00, 8'h53, 1'b1, 1'b1);
      wait_idle();
      issue(1'b0, 7'h24, 8'h10, 8'hA5, 8'h00, 1'b1, 1'b1);
      wait_idle();

      // Second START while busy must be ignored.
      issue(1'b0, 7'h23, 8'h3C, 8'h81, 8'h00, 1'b1, 1'b1);
      repeat (60) @(negedge clk);
      chk("busy_mid_txn", busy, 1'b1);
      start = 1'b1; rw = 1'b1; dev = 7'h24; wd = 8'h00;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      repeat (40) @(negedge clk);

      // Reset during REG bit 4 (13th SCL fall of the transaction).
      issue(1'b0, 7'h23, 8'hC3, 8'h5A, 8'h00, 1'b0, 1'b1);
      k = 0;
      while (falls < 13 && k < 600) begin
         @(negedge clk);
         k++;
      end
      chk("reached_reg_bit4", (falls >= 13), 1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_scl", scl_w, 1'b1);
      chk("midrst_sda", sda_w, 1'b1);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", done, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      model_rdata = '0;
      repeat (30) @(negedge clk);
      issue(1'b0, 7'h23, 8'h77, 8'h0F, 8'h00, 1'b1, 1'b1);
      wait_idle();

      b2b = 1'b0;
      for (int i = 0; i < 12; i++) begin
         logic       r;
         logic [6:0] d;
         r = 1'($urandom);
         d = ($urandom_range(0, 3) == 0) ? 7'($urandom) : SLV_ADDR;
         issue(r, d, 8'($urandom), 8'($urandom), 8'($urandom), 1'b1, !b2b);
         if ($urandom_range(0, 1) == 1) begin
            wait_done();
            b2b = 1'b1;
         end else begin
            wait_idle();
            b2b = 1'b0;
         end
      end
      wait_idle();
      repeat (10) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Single-master I2C bus controller that generates SCL and drives SDA toward the team's I2C slave (device address 7'h23).
- Runs one transaction per request:
  - Write: START, device address + W, register address, one data byte, STOP.
  - Read: START, device address + R, one data byte (master NACKs), STOP.
- Sits between the host register/command logic and the open-drain bus pins. The slave sees SCL as an input and SDA as a shared wire.

Parameters:
- CLK_DIV, 4: SYSTEM_CLK cycles per SCL quarter-period. SCL period = 4*CLK_DIV cycles; legal range 2..255.

Ports:
- SYSTEM_CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- START  input  1  request pulse; accepted only when BUSY=0.
- RW  input  1  0=write transaction, 1=read transaction; latched on accept.
- DEV_ADDR  input  7  target device address; latched on accept.
- REG_ADDR  input  8  register address (write only); latched on accept.
- WDATA  input  8  write data byte; latched on accept.
- RDATA  output  8  last byte read from the bus.
- BUSY  output  1  transaction in progress.
- DONE  output  1  one-cycle pulse at transaction end.
- ACK_ERR  output  1  NACK received during the last transaction.
- SCL  output  1  open-drain clock: drives 1'b0 or 1'bz.
- SDA  inout  1  open-drain data: drives 1'b0 or 1'bz; sampled when released.

Behaviour:
- Reset values: RDATA=0, BUSY=0, DONE=0, ACK_ERR=0; SCL=z and SDA=z; FSM=IDLE; divider and bit counters=0.
- Reset mid-transaction: the bus is released on the next clock and the FSM returns to IDLE. No STOP is generated and no DONE pulse is issued.
- Quarter tick:
  - Divider counts 0..CLK_DIV-1. The tick fires on terminal count; FSM phase steps advance only on a tick.
  - The divider is held at 0 in IDLE.
- Request accept: START=1 with BUSY=0 in IDLE.
  - Inputs are latched, ACK_ERR is cleared, and BUSY=1 from the next cycle.
  - START is ignored while BUSY=1.
- FSM states and transitions:
  - IDLE -> S_START -> ADDR -> ADDR_ACK.
  - ADDR_ACK, on ACK: RW=0 -> REG; RW=1 -> RDAT.
  - REG -> REG_ACK -> WDAT -> WDAT_ACK -> S_STOP.
  - RDAT -> RDAT_NACK -> S_STOP.
  - S_STOP -> IDLE.
- NACK handling: a NACK (SDA sampled 1) in ADDR_ACK, REG_ACK or WDAT_ACK sets ACK_ERR=1 and goes directly to S_STOP.
- S_START, 2 quarters:
  - Q0: SCL=z, SDA=z.
  - Q1: SCL=z, SDA=0 (falling SDA while SCL high).
- Bit slot, 4 quarters:
  - Q0: SCL=0, SDA updated to the bit value (0 -> 0, 1 -> z).
  - Q1: SCL=0.
  - Q2: SCL=z.
  - Q3: SCL=z. SDA is sampled on entry to Q3.
  - Bytes are transmitted MSB first.
- Byte contents:
  - ADDR byte = {DEV_ADDR, RW}.
  - ACK slots (ADDR_ACK, REG_ACK, WDAT_ACK): master releases SDA and samples it; 0 means ACK.
  - RDAT: master releases SDA and shifts the sampled bits MSB first. RDATA updates once, on the Q3 sample of bit 0.
  - RDAT_NACK: master releases SDA (NACK).
- S_STOP, 3 quarters:
  - Q0: SCL=0, SDA=0.
  - Q1: SCL=z, SDA=0.
  - Q2: SCL=z, SDA=z (rising SDA while SCL high).
- Completion: at the end of S_STOP Q2, DONE=1 for exactly one cycle, BUSY=0 in the same cycle, and the FSM is back in IDLE. A new START is accepted from the following cycle.
- SDA changes only while SCL=0, except inside START and STOP.
- Latency from the accept cycle to DONE:
  - Write with full ACK: (2 + 27*4 + 3) * CLK_DIV = 113*CLK_DIV cycles, plus 1.
  - Read: (2 + 18*4 + 3) * CLK_DIV = 77*CLK_DIV cycles, plus 1.
  - Address NACK: (2 + 9*4 + 3) * CLK_DIV, plus 1.
- Clock stretching and multi-master arbitration are not supported: SCL is never sampled.

Test Plan:
- Write, DEV_ADDR=7'h23, REG_ADDR=8'h10, WDATA=8'hA5, slave model ACKs every byte -> bus bytes 8'h46, 8'h10, 8'hA5 seen in order; ACK_ERR=0; DONE 1 cycle at 453 cycles after accept (CLK_DIV=4).
- Read, DEV_ADDR=7'h23, slave model returns 8'h53 -> bus byte 8'h47; RDATA=8'h53; master leaves SDA released in the 9th slot; DONE at 309 cycles; BUSY falls in the DONE cycle.
- Write to DEV_ADDR=7'h24, no device ACK -> ACK_ERR=1; STOP follows immediately after the address ACK slot; DONE at 165 cycles; no REG byte on the bus.
- START re-pulsed mid-transaction with different DEV_ADDR/WDATA -> ignored; bus bytes match the first request; only one DONE.
- RESET asserted during REG bit 4 -> next cycle SCL=z, SDA=z, BUSY=0, no DONE; a following write transaction completes normally.
- Protocol checker over all scenarios -> SDA never toggles while SCL is released, except on the START falling edge and the STOP rising edge; SCL period is exactly 16 cycles at CLK_DIV=4.
